// File: rtl/fma_operand_unpacker_if.sv
// Operand-in / unpacked-fields-out bus of the FMA operand unpacker.
// Both handshakes (input beat and output beat) are carried here.
interface fma_operand_unpacker_if #(
  parameter int unsigned PARM_EXP  = 8,
  parameter int unsigned PARM_MANT = 23,
  parameter int unsigned PARM_RM   = 3
);
  localparam int unsigned W = PARM_EXP + PARM_MANT + 1;

  logic                 Valid_i;
  logic                 Ready_o;
  logic [W-1:0]         A_i, B_i, C_i;
  logic [1:0]           Op_i;
  logic [PARM_RM-1:0]   Rm_i, Frm_i;

  logic                 Valid_o;
  logic                 Ready_i;
  logic                 A_Sign_o, B_Sign_o, C_Sign_o;
  logic [PARM_EXP-1:0]  A_Exp_o, B_Exp_o, C_Exp_o;
  logic [PARM_MANT:0]   A_Mant_o, B_Mant_o, C_Mant_o;
  logic                 A_Zero_o, A_Inf_o, A_NaN_o, A_DeN_o;
  logic                 B_Zero_o, B_Inf_o, B_NaN_o, B_DeN_o;
  logic                 C_Zero_o, C_Inf_o, C_NaN_o, C_DeN_o;
  logic                 Sub_Sign_o;
  logic [PARM_RM-1:0]   Rounding_mode_o;
  logic                 Rm_illegal_o;

  modport slave (
    input  Valid_i, A_i, B_i, C_i, Op_i, Rm_i, Frm_i, Ready_i,
    output Ready_o, Valid_o,
           A_Sign_o, B_Sign_o, C_Sign_o,
           A_Exp_o, B_Exp_o, C_Exp_o,
           A_Mant_o, B_Mant_o, C_Mant_o,
           A_Zero_o, A_Inf_o, A_NaN_o, A_DeN_o,
           B_Zero_o, B_Inf_o, B_NaN_o, B_DeN_o,
           C_Zero_o, C_Inf_o, C_NaN_o, C_DeN_o,
           Sub_Sign_o, Rounding_mode_o, Rm_illegal_o
  );

  modport master (
    output Valid_i, A_i, B_i, C_i, Op_i, Rm_i, Frm_i, Ready_i,
    input  Ready_o, Valid_o,
           A_Sign_o, B_Sign_o, C_Sign_o,
           A_Exp_o, B_Exp_o, C_Exp_o,
           A_Mant_o, B_Mant_o, C_Mant_o,
           A_Zero_o, A_Inf_o, A_NaN_o, A_DeN_o,
           B_Zero_o, B_Inf_o, B_NaN_o, B_DeN_o,
           C_Zero_o, C_Inf_o, C_NaN_o, C_DeN_o,
           Sub_Sign_o, Rounding_mode_o, Rm_illegal_o
  );
endinterface

// File: rtl/fma_operand_unpacker.sv
// FMA front end: opcode sign handling, operand classification, rounding-mode
// resolution, behind a registered valid/ready stage with skid. Macro: UNPACK_FTZ_EN.
module fma_operand_unpacker #(
  parameter int unsigned        PARM_EXP    = 8,
  parameter int unsigned        PARM_MANT   = 23,
  parameter int unsigned        PARM_RM     = 3,
  parameter logic [PARM_RM-1:0] PARM_RM_DYN = 3'b111
) (
  input  logic clk_i,
  input  logic rst_ni,
  fma_operand_unpacker_if.slave bus
);
  localparam int unsigned W = PARM_EXP + PARM_MANT + 1;

  typedef struct packed {
    logic                sign;
    logic [PARM_EXP-1:0] exp;
    logic [PARM_MANT:0]  mant;
    logic                zero;
    logic                inf;
    logic                nan;
    logic                den;
  } opnd_t;

  typedef struct packed {
    opnd_t              a;
    opnd_t              b;
    opnd_t              c;
    logic               sub;
    logic [PARM_RM-1:0] rm;
    logic               ill;
  } beat_t;

  function automatic opnd_t unpack(input logic [W-1:0] x, input logic flip);
    opnd_t                o;
    logic [PARM_EXP-1:0]  e;
    logic [PARM_MANT-1:0] f;
    logic                 e_zero, e_ones, f_zero;
    e      = x[W-2:PARM_MANT];
    f      = x[PARM_MANT-1:0];
    e_zero = (e == '0);
    e_ones = &e;
    f_zero = (f == '0);
    o.sign = x[W-1] ^ flip;
    o.exp  = e;
    o.mant = {~e_zero, f};
    o.zero = e_zero & f_zero;
    o.inf  = e_ones & f_zero;
    o.nan  = e_ones & ~f_zero;
    o.den  = e_zero & ~f_zero;
`ifdef UNPACK_FTZ_EN
    if (o.den) begin
      o.zero = 1'b1;
      o.den  = 1'b0;
      o.mant = '0;
    end
`endif
    return o;
  endfunction

  beat_t              dec;
  logic [PARM_RM-1:0] rm_res;

  // Combinational decode of the incoming beat
  always_comb begin
    dec.a   = unpack(bus.A_i, bus.Op_i[0]);
    dec.b   = unpack(bus.B_i, bus.Op_i[1]);
    dec.c   = unpack(bus.C_i, 1'b0);
    dec.sub = dec.a.sign ^ dec.b.sign ^ dec.c.sign;
    rm_res  = (bus.Rm_i == PARM_RM_DYN) ? bus.Frm_i : bus.Rm_i;
    dec.ill = (rm_res == PARM_RM'(5)) || (rm_res == PARM_RM'(6)) ||
              (rm_res == PARM_RM'(7));
    dec.rm  = dec.ill ? '0 : rm_res;
  end

  beat_t main_q, main_d, skid_q, skid_d;
  logic  main_vq, main_vd, skid_vq, skid_vd, ready_q, ready_d;
  logic  accept, drain;

  // Next-state of the main/skid pair; skid only fills when main is stuck
  always_comb begin
    main_d  = main_q;
    main_vd = main_vq;
    skid_d  = skid_q;
    skid_vd = skid_vq;
    accept  = bus.Valid_i & ready_q;
    drain   = main_vq & bus.Ready_i;
    if (drain) begin
      if (skid_vq) begin
        main_d  = skid_q;
        skid_vd = 1'b0;
      end else begin
        main_vd = 1'b0;
      end
    end
    if (accept) begin
      if (!main_vd) begin
        main_d  = dec;
        main_vd = 1'b1;
      end else begin
        skid_d  = dec;
        skid_vd = 1'b1;
      end
    end
    ready_d = ~skid_vd;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_q  <= '0;
      main_vq <= 1'b0;
      skid_q  <= '0;
      skid_vq <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      main_q  <= main_d;
      main_vq <= main_vd;
      skid_q  <= skid_d;
      skid_vq <= skid_vd;
      ready_q <= ready_d;
    end
  end

  assign bus.Ready_o         = ready_q;
  assign bus.Valid_o         = main_vq;
  assign bus.A_Sign_o        = main_q.a.sign;
  assign bus.B_Sign_o        = main_q.b.sign;
  assign bus.C_Sign_o        = main_q.c.sign;
  assign bus.A_Exp_o         = main_q.a.exp;
  assign bus.B_Exp_o         = main_q.b.exp;
  assign bus.C_Exp_o         = main_q.c.exp;
  assign bus.A_Mant_o        = main_q.a.mant;
  assign bus.B_Mant_o        = main_q.b.mant;
  assign bus.C_Mant_o        = main_q.c.mant;
  assign bus.A_Zero_o        = main_q.a.zero;
  assign bus.A_Inf_o         = main_q.a.inf;
  assign bus.A_NaN_o         = main_q.a.nan;
  assign bus.A_DeN_o         = main_q.a.den;
  assign bus.B_Zero_o        = main_q.b.zero;
  assign bus.B_Inf_o         = main_q.b.inf;
  assign bus.B_NaN_o         = main_q.b.nan;
  assign bus.B_DeN_o         = main_q.b.den;
  assign bus.C_Zero_o        = main_q.c.zero;
  assign bus.C_Inf_o         = main_q.c.inf;
  assign bus.C_NaN_o         = main_q.c.nan;
  assign bus.C_DeN_o         = main_q.c.den;
  assign bus.Sub_Sign_o      = main_q.sub;
  assign bus.Rounding_mode_o = main_q.rm;
  assign bus.Rm_illegal_o    = main_q.ill;
endmodule

// File: tb/tb_fma_operand_unpacker.sv
// Self-checking bench for fma_operand_unpacker: directed table, handshake
// corner sequences and randomized traffic against a spec-level model.
module tb_fma_operand_unpacker;
`ifdef UNPACK_FTZ_EN
  localparam bit FTZ = 1'b1;
`else
  localparam bit FTZ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fma_operand_unpacker_if bus ();
  fma_operand_unpacker dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic        as, bs, cs;
    logic [7:0]  ae, be, ce;
    logic [23:0] am, bm, cm;
    logic [11:0] fl;   // {A zero,inf,nan,den, B ..., C ...}
    logic        sub;
    logic [2:0]  rm;
    logic        ill;
  } res_t;

  typedef struct {
    logic [31:0] a, b, c;
    logic [1:0]  op;
    logic [2:0]  rm, frm;
    logic [11:0] fl;
    logic [2:0]  sg;
    logic        sub;
    logic [2:0]  rmo;
    logic        ill;
    logic [23:0] am, bm, cm;
    logic [7:0]  be;
  } vec_t;

  // Reference: IEEE-754 field rules applied operand by operand
  function automatic res_t model(input logic [31:0] a, b, c, input logic [1:0] op,
                                 input logic [2:0] rm, frm);
    res_t        r;
    logic [31:0] v [3];
    logic [7:0]  e [3];
    logic [23:0] m [3];
    logic [3:0]  cl [3];
    logic [2:0]  s;
    int unsigned mode, negs;
    v[0] = a; v[1] = b; v[2] = c;
    for (int i = 0; i < 3; i++) begin
      int unsigned ex, fr;
      ex = (v[i] >> 23) & 32'hFF;
      fr = v[i] & 32'h7FFFFF;
      e[i] = 8'(ex);
      m[i] = 24'((ex != 0 ? 32'h800000 : 32'h0) + fr);
      cl[i] = {ex == 0 && fr == 0, ex == 255 && fr == 0, ex == 255 && fr != 0, ex == 0 && fr != 0};
      if (FTZ && ex == 0 && fr != 0) begin
        cl[i] = 4'b1000;
        m[i]  = 24'd0;
      end
    end
    s[2] = a[31] ^ op[0];
    s[1] = b[31] ^ op[1];
    s[0] = c[31];
    negs = 32'(s[2]) + 32'(s[1]) + 32'(s[0]);
    mode = (rm == 3'd7) ? 32'(frm) : 32'(rm);
    r.as = s[2]; r.bs = s[1]; r.cs = s[0];
    r.ae = e[0]; r.be = e[1]; r.ce = e[2];
    r.am = m[0]; r.bm = m[1]; r.cm = m[2];
    r.fl = {cl[0], cl[1], cl[2]};
    r.sub = (negs % 2) == 1;
    r.ill = mode >= 5;
    r.rm  = r.ill ? 3'd0 : 3'(mode);
    return r;
  endfunction

  function automatic res_t actual();
    res_t r;
    r.as = bus.A_Sign_o; r.bs = bus.B_Sign_o; r.cs = bus.C_Sign_o;
    r.ae = bus.A_Exp_o;  r.be = bus.B_Exp_o;  r.ce = bus.C_Exp_o;
    r.am = bus.A_Mant_o; r.bm = bus.B_Mant_o; r.cm = bus.C_Mant_o;
    r.fl = {bus.A_Zero_o, bus.A_Inf_o, bus.A_NaN_o, bus.A_DeN_o,
            bus.B_Zero_o, bus.B_Inf_o, bus.B_NaN_o, bus.B_DeN_o,
            bus.C_Zero_o, bus.C_Inf_o, bus.C_NaN_o, bus.C_DeN_o};
    r.sub = bus.Sub_Sign_o; r.rm = bus.Rounding_mode_o; r.ill = bus.Rm_illegal_o;
    return r;
  endfunction

  task automatic check_res(input string nm, input res_t got, input res_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", nm, got, exp);
    end
  endtask

  task automatic check_bit(input string nm, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%b expected=%b", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, b, c, input logic [1:0] op,
                       input logic [2:0] rm, frm);
    bus.Valid_i = v; bus.A_i = a; bus.B_i = b; bus.C_i = c;
    bus.Op_i = op; bus.Rm_i = rm; bus.Frm_i = frm;
  endtask

  function automatic logic [31:0] rand_fp();
    logic [7:0]  ex;
    logic [22:0] fr;
    case ($urandom_range(0, 3))
      0: ex = 8'h00;
      1: ex = 8'hFF;
      default: ex = 8'($urandom);
    endcase
    fr = ($urandom_range(0, 2) == 0) ? 23'd0 : 23'($urandom);
    return {1'($urandom), ex, fr};
  endfunction

  vec_t tbl [10];
  res_t q [$];
  res_t exp_r, held;
  logic [31:0] ra, rb, rc;
  logic [1:0]  rop;
  logic [2:0]  rrm, rfrm;
  int          guard;

  initial begin
    tbl[0] = '{32'h3F800000, 32'h40000000, 32'h40400000, 2'b00, 3'b000, 3'b000,
               12'h000, 3'b000, 1'b0, 3'b000, 1'b0, 24'h800000, 24'h800000, 24'hC00000, 8'h80};
    tbl[1] = '{32'h00000001, 32'h3F800000, 32'h3F800000, 2'b00, 3'b001, 3'b000,
               FTZ ? 12'h800 : 12'h100, 3'b000, 1'b0, 3'b001, 1'b0,
               FTZ ? 24'h0 : 24'h000001, 24'h800000, 24'h800000, 8'h7F};
    tbl[2] = '{32'h3F800000, 32'h7F800000, 32'h00000000, 2'b01, 3'b000, 3'b000,
               12'h048, 3'b100, 1'b1, 3'b000, 1'b0, 24'h800000, 24'h800000, 24'h000000, 8'hFF};
    tbl[3] = '{32'h3F800000, 32'h7F800000, 32'h7FC00000, 2'b01, 3'b000, 3'b000,
               12'h042, 3'b100, 1'b1, 3'b000, 1'b0, 24'h800000, 24'h800000, 24'hC00000, 8'hFF};
    tbl[4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 2'b00, 3'b111, 3'b010,
               12'h000, 3'b000, 1'b0, 3'b010, 1'b0, 24'h800000, 24'h800000, 24'hC00000, 8'h80};
    tbl[5] = '{32'h3F800000, 32'h40000000, 32'h40400000, 2'b00, 3'b111, 3'b101,
               12'h000, 3'b000, 1'b0, 3'b000, 1'b1, 24'h800000, 24'h800000, 24'hC00000, 8'h80};
    tbl[6] = '{32'h3F800000, 32'h40000000, 32'h40400000, 2'b00, 3'b110, 3'b000,
               12'h000, 3'b000, 1'b0, 3'b000, 1'b1, 24'h800000, 24'h800000, 24'hC00000, 8'h80};
    tbl[7] = '{32'hBF800000, 32'hC0000000, 32'h40400000, 2'b11, 3'b100, 3'b000,
               12'h000, 3'b000, 1'b0, 3'b100, 1'b0, 24'h800000, 24'h800000, 24'hC00000, 8'h80};
    tbl[8] = '{32'h00000000, 32'h3F800000, 32'hC0400000, 2'b10, 3'b011, 3'b000,
               12'h800, 3'b011, 1'b0, 3'b011, 1'b0, 24'h000000, 24'h800000, 24'hC00000, 8'h7F};
    tbl[9] = '{32'h3F800000, 32'h40000000, 32'h40400000, 2'b00, 3'b101, 3'b001,
               12'h000, 3'b000, 1'b0, 3'b000, 1'b1, 24'h800000, 24'h800000, 24'hC00000, 8'h80};

    bus.Ready_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 2'b00, 3'b000, 3'b000);
    tick(); tick();
    check_bit("reset_valid", bus.Valid_o, 1'b0);
    check_res("reset_fields", actual(), '0);
    rst_n = 1'b1;
    tick();
    check_bit("ready_after_release", bus.Ready_o, 1'b1);

    // Directed vectors, one beat each, downstream always ready
    bus.Ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].op, tbl[i].rm, tbl[i].frm);
      tick();
      bus.Valid_i = 1'b0;
      check_bit($sformatf("vec%0d_valid", i), bus.Valid_o, 1'b1);
      n_cmp++;
      if ({bus.A_Zero_o, bus.A_Inf_o, bus.A_NaN_o, bus.A_DeN_o,
           bus.B_Zero_o, bus.B_Inf_o, bus.B_NaN_o, bus.B_DeN_o,
           bus.C_Zero_o, bus.C_Inf_o, bus.C_NaN_o, bus.C_DeN_o,
           bus.A_Sign_o, bus.B_Sign_o, bus.C_Sign_o, bus.Sub_Sign_o,
           bus.Rounding_mode_o, bus.Rm_illegal_o,
           bus.A_Mant_o, bus.B_Mant_o, bus.C_Mant_o, bus.B_Exp_o} !==
          {tbl[i].fl, tbl[i].sg, tbl[i].sub, tbl[i].rmo, tbl[i].ill,
           tbl[i].am, tbl[i].bm, tbl[i].cm, tbl[i].be}) begin
        n_bad++;
        $display("FAIL vec%0d_fields: got fl=%h sg=%b sub=%b rm=%b ill=%b am=%h bm=%h cm=%h be=%h expected fl=%h sg=%b sub=%b rm=%b ill=%b am=%h bm=%h cm=%h be=%h",
                 i, actual().fl, {bus.A_Sign_o, bus.B_Sign_o, bus.C_Sign_o}, bus.Sub_Sign_o,
                 bus.Rounding_mode_o, bus.Rm_illegal_o, bus.A_Mant_o, bus.B_Mant_o, bus.C_Mant_o,
                 bus.B_Exp_o, tbl[i].fl, tbl[i].sg, tbl[i].sub, tbl[i].rmo, tbl[i].ill,
                 tbl[i].am, tbl[i].bm, tbl[i].cm, tbl[i].be);
      end
      check_res($sformatf("vec%0d_model", i), actual(),
                model(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].op, tbl[i].rm, tbl[i].frm));
    end
    tick();
    check_bit("idle_valid", bus.Valid_o, 1'b0);

    // Back-pressure: three beats while stalled
    bus.Ready_i = 1'b0;
    drive(1'b1, 32'h3F800000, 32'h40000000, 32'h40400000, 2'b00, 3'b000, 3'b000);
    tick();
    check_bit("bp_ready_after_1", bus.Ready_o, 1'b1);
    drive(1'b1, 32'h00000001, 32'h7F800000, 32'hC0400000, 2'b01, 3'b001, 3'b000);
    tick();
    check_bit("bp_ready_after_2", bus.Ready_o, 1'b0);
    drive(1'b1, 32'h7FC00000, 32'h80000000, 32'h3F800000, 2'b10, 3'b111, 3'b011);
    tick();
    check_res("bp_hold_beat1", actual(), model(32'h3F800000, 32'h40000000, 32'h40400000, 2'b00, 3'b000, 3'b000));
    bus.Ready_i = 1'b1;
    tick();
    check_res("bp_beat2", actual(), model(32'h00000001, 32'h7F800000, 32'hC0400000, 2'b01, 3'b001, 3'b000));
    check_bit("bp_ready_reopen", bus.Ready_o, 1'b1);
    tick();
    bus.Valid_i = 1'b0;
    check_bit("bp_beat3_valid", bus.Valid_o, 1'b1);
    check_res("bp_beat3", actual(), model(32'h7FC00000, 32'h80000000, 32'h3F800000, 2'b10, 3'b111, 3'b011));
    tick();
    check_bit("bp_empty", bus.Valid_o, 1'b0);

    // Reset with both entries full
    bus.Ready_i = 1'b0;
    drive(1'b1, 32'h40000000, 32'h40000000, 32'h40000000, 2'b00, 3'b000, 3'b000);
    tick(); tick();
    bus.Valid_i = 1'b0;
    check_bit("rst_pre_ready", bus.Ready_o, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_bit("rst_async_valid", bus.Valid_o, 1'b0);
    check_res("rst_async_fields", actual(), '0);
    tick();
    rst_n = 1'b1;
    bus.Ready_i = 1'b1;
    tick();
    check_bit("rst_release_ready", bus.Ready_o, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check_bit($sformatf("rst_no_stale%0d", i), bus.Valid_o, 1'b0);
      tick();
    end

    // Randomized traffic with a scoreboard queue
    for (int cyc = 0; cyc < 600; cyc++) begin
      ra = rand_fp(); rb = rand_fp(); rc = rand_fp();
      rop = 2'($urandom); rrm = 3'($urandom); rfrm = 3'($urandom);
      drive($urandom_range(0, 3) != 0, ra, rb, rc, rop, rrm, rfrm);
      bus.Ready_i = $urandom_range(0, 2) != 0;
      if (bus.Valid_i && bus.Ready_o) q.push_back(model(ra, rb, rc, rop, rrm, rfrm));
      if (bus.Valid_o && bus.Ready_i) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rnd_extra_beat: got an output beat, expected none at cycle %0d", cyc);
        end else begin
          exp_r = q.pop_front();
          check_res($sformatf("rnd_beat_c%0d", cyc), actual(), exp_r);
        end
      end else if (bus.Valid_o) begin
        held = actual();
        tick();
        check_res($sformatf("rnd_hold_c%0d", cyc), actual(), held);
        continue;
      end
      tick();
    end
    bus.Valid_i = 1'b0;
    bus.Ready_i = 1'b1;
    guard = 0;
    while (q.size() != 0 && guard < 10) begin
      if (bus.Valid_o) begin
        exp_r = q.pop_front();
        check_res("rnd_drain", actual(), exp_r);
      end
      tick();
      guard++;
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL rnd_drain_left: got %0d beats outstanding, expected 0", q.size());
    end
    check_bit("final_empty", bus.Valid_o, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
